// File: rtl/spi_mst_if.sv
// Local request/response bus between a register requester and the SPI master.
// Combinational bundle only; no storage.
// Requester holds i_req until it sees o_ready; spi_mst never stalls o_done.
interface spi_mst_if #(
    parameter int REG_AW = 7,
    parameter int REG_DW = 8
);
    logic              i_req;
    logic              i_wr;
    logic [REG_AW-1:0] i_addr;
    logic [REG_DW-1:0] i_wdata;
    logic              o_ready;
    logic              o_done;
    logic [REG_DW-1:0] o_rdata;
    logic              o_crc_err;
    logic              o_rsp_err;

    // Requester side: issues accesses, receives completion.
    modport master (
        output i_req, i_wr, i_addr, i_wdata,
        input  o_ready, o_done, o_rdata, o_crc_err, o_rsp_err
    );

    // SPI master side: accepts accesses, returns completion.
    modport slave (
        input  i_req, i_wr, i_addr, i_wdata,
        output o_ready, o_done, o_rdata, o_crc_err, o_rsp_err
    );
endinterface

// File: rtl/spi_mst.sv
// SPI master for the 24-bit CRC-protected register protocol: command frame then poll frame.
// Latency accept->o_done = 2*50*SCK_HALF + CSB_GAP + 1 cycles; all outputs registered.
// No backpressure: requests arriving while busy are dropped, o_ready marks the only accept window.

// CRC-8, polynomial x^8+x^2+x+1, zero init, over a 16-bit word MSB first.
module crc16to8_parallel (
    input  logic [15:0] data_i,
    output logic [7:0]  crc_o
);
    logic [7:0] c;
    logic       fb;

    // Unrolled bit-serial CRC; collapses to an XOR tree.
    always_comb begin
        c  = 8'h00;
        fb = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ data_i[i];
            c  = {c[6:0], 1'b0} ^ ({8{fb}} & 8'h07);
        end
        crc_o = c;
    end
endmodule

module spi_mst #(
    parameter int                REG_AW    = 7,
    parameter int                REG_DW    = 8,
    parameter int                REG_CRC_W = 8,
    parameter int                SCK_HALF  = 2,
    parameter int                CSB_GAP   = 64,
    parameter logic [REG_AW-1:0] POLL_ADDR = '0
) (
    input  logic       i_spi_sclk,
    input  logic       i_rst_n,
    spi_mst_if.slave   req_if,
    output logic       o_spi_sclk,
    output logic       o_spi_csb,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);
    // The link word is fixed at 24 bits: {wr/flag, addr[6:0], data[7:0], crc[7:0]}.
    localparam int FRAME_W = 1 + REG_AW + REG_DW + REG_CRC_W;
    localparam int PAY_W   = 1 + REG_AW + REG_DW;
    localparam int HALF_N  = 2 * FRAME_W;
    localparam int CNT_MAX = (CSB_GAP > SCK_HALF) ? CSB_GAP : SCK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HALF_W  = $clog2(HALF_N);

    localparam logic [CNT_W-1:0]  SH_LAST   = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CSB_GAP - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               frame_q;     // 0 = command frame, 1 = poll frame
    logic [CNT_W-1:0]   cnt_q;       // half-period / lead / trail / gap counter
    logic [HALF_W-1:0]  half_q;      // SCLK half-period index within SHIFT
    logic [FRAME_W-1:0] tx_q;
    logic [FRAME_W-1:0] rx_q;
    logic               wr_q;
    logic [REG_AW-1:0]  addr_q;
    logic               ready_q;
    logic               done_q;
    logic [REG_DW-1:0]  rdata_q;
    logic               crc_err_q;
    logic               rsp_err_q;
    logic               sclk_q;
    logic               csb_q;
    logic               mosi_q;

    logic [PAY_W-1:0]     tx_pay_d;
    logic [REG_CRC_W-1:0] tx_crc;
    logic [FRAME_W-1:0]   tx_word_d;
    logic [REG_CRC_W-1:0] rx_crc;
    logic                 crc_err_d;
    logic                 rsp_err_d;

    // TX payload: the live request while idle (command frame), else the fixed poll read.
    always_comb begin
        tx_pay_d = {1'b0, POLL_ADDR, {REG_DW{1'b0}}};
        if (state_q == S_IDLE) begin
            tx_pay_d = {req_if.i_wr, req_if.i_addr,
                        req_if.i_wr ? req_if.i_wdata : {REG_DW{1'b0}}};
        end
    end

    crc16to8_parallel u_crc_tx (
        .data_i (tx_pay_d),
        .crc_o  (tx_crc)
    );

    assign tx_word_d = {tx_pay_d, tx_crc};

    crc16to8_parallel u_crc_rx (
        .data_i (rx_q[FRAME_W-1 -: PAY_W]),
        .crc_o  (rx_crc)
    );

    // Response check; a bad CRC masks the type/address check.
    always_comb begin
        crc_err_d = (rx_crc != rx_q[REG_CRC_W-1:0]);
        rsp_err_d = !crc_err_d &&
                    ((rx_q[FRAME_W-1] != wr_q) ||
                     (rx_q[FRAME_W-2 -: REG_AW] != addr_q));
    end

    // Frame sequencer with registered pin and status outputs.
    always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= 1'b0;
            cnt_q     <= '0;
            half_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            crc_err_q <= 1'b0;
            rsp_err_q <= 1'b0;
            sclk_q    <= 1'b0;
            csb_q     <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    csb_q  <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (req_if.i_req && ready_q) begin
                        wr_q    <= req_if.i_wr;
                        addr_q  <= req_if.i_addr;
                        frame_q <= 1'b0;
                        tx_q    <= tx_word_d;
                        mosi_q  <= tx_word_d[FRAME_W-1];
                        csb_q   <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    // CSB low, first bit already on MOSI, SCLK held low.
                    if (cnt_q == SH_LAST) begin
                        cnt_q   <= '0;
                        half_q  <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == SH_LAST) begin
                        cnt_q <= '0;
                        if (half_q == HALF_LAST) begin
                            // 24th falling edge: park MOSI low and trail.
                            sclk_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                            state_q <= S_TRAIL;
                        end else begin
                            half_q <= half_q + HALF_W'(1);
                            sclk_q <= ~sclk_q;
                            if (!sclk_q) begin
                                rx_q <= {rx_q[FRAME_W-2:0], i_spi_miso};
                            end else begin
                                tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
                                mosi_q <= tx_q[FRAME_W-2];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (cnt_q == SH_LAST) begin
                        cnt_q <= '0;
                        csb_q <= 1'b1;
                        if (!frame_q) begin
                            state_q <= S_GAP;
                        end else begin
                            done_q    <= 1'b1;
                            rdata_q   <= rx_q[REG_CRC_W +: REG_DW];
                            crc_err_q <= crc_err_d;
                            rsp_err_q <= rsp_err_d;
                            state_q   <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    // Give the slave time to sync CSB, access the register and stage its ack.
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        frame_q <= 1'b1;
                        tx_q    <= tx_word_d;
                        mosi_q  <= tx_word_d[FRAME_W-1];
                        csb_q   <= 1'b0;
                        state_q <= S_LEAD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_if.o_ready   = ready_q;
    assign req_if.o_done    = done_q;
    assign req_if.o_rdata   = rdata_q;
    assign req_if.o_crc_err = crc_err_q;
    assign req_if.o_rsp_err = rsp_err_q;
    assign o_spi_sclk       = sclk_q;
    assign o_spi_csb        = csb_q;
    assign o_spi_mosi       = mosi_q;
endmodule

// File: tb/tb_spi_mst.sv
// Directed bench for spi_mst: default instance plus a SCK_HALF=1 / CSB_GAP=8 instance.
// Acts as remote slave on MISO, captures MOSI per frame and checks timing and status.
module tb_spi_mst;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       miso  = 1'b1;
    logic       sel   = 1'b0;
    logic       req   = 1'b0;
    logic       wr    = 1'b0;
    logic [6:0] addr  = 7'h00;
    logic [7:0] wdata = 8'h00;

    logic sclk0, csb0, mosi0, sclk1, csb1, mosi1;

    spi_mst_if #(.REG_AW(7), .REG_DW(8)) bus0 ();
    spi_mst_if #(.REG_AW(7), .REG_DW(8)) bus1 ();

    assign bus0.i_req   = req & ~sel;
    assign bus0.i_wr    = wr;
    assign bus0.i_addr  = addr;
    assign bus0.i_wdata = wdata;
    assign bus1.i_req   = req & sel;
    assign bus1.i_wr    = wr;
    assign bus1.i_addr  = addr;
    assign bus1.i_wdata = wdata;

    spi_mst u_dut0 (
        .i_spi_sclk (clk),
        .i_rst_n    (rst_n),
        .req_if     (bus0.slave),
        .o_spi_sclk (sclk0),
        .o_spi_csb  (csb0),
        .o_spi_mosi (mosi0),
        .i_spi_miso (miso)
    );

    spi_mst #(.SCK_HALF(1), .CSB_GAP(8)) u_dut1 (
        .i_spi_sclk (clk),
        .i_rst_n    (rst_n),
        .req_if     (bus1.slave),
        .o_spi_sclk (sclk1),
        .o_spi_csb  (csb1),
        .o_spi_mosi (mosi1),
        .i_spi_miso (miso)
    );

    always #5 clk = ~clk;

    logic       m_sclk, m_csb, m_mosi, m_ready, m_done, m_crc, m_rsp;
    logic [7:0] m_rdata;
    assign m_sclk  = sel ? sclk1 : sclk0;
    assign m_csb   = sel ? csb1  : csb0;
    assign m_mosi  = sel ? mosi1 : mosi0;
    assign m_ready = sel ? bus1.o_ready   : bus0.o_ready;
    assign m_done  = sel ? bus1.o_done    : bus0.o_done;
    assign m_rdata = sel ? bus1.o_rdata   : bus0.o_rdata;
    assign m_crc   = sel ? bus1.o_crc_err : bus0.o_crc_err;
    assign m_rsp   = sel ? bus1.o_rsp_err : bus0.o_rsp_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] last_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC-8, poly 0x07, zero init, MSB first.
    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    typedef struct {
        logic       s;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       rflag;
        logic [6:0] raddr;
        logic [7:0] rdata;
        logic [7:0] crc_flip;
        logic       poke;
        logic [7:0] exp_rdata;
        logic       exp_crc;
        logic       exp_rsp;
    } vec_t;

    vec_t tbl [9];

    task automatic run_txn(input vec_t v);
        int          sh, gap, lat, cyc, frames, rises, fall_cyc, rise_cyc, viol, idx, extra;
        logic        pcsb, psclk, pmosi, done_seen, poked;
        logic [23:0] resp, exp1, exp2, mosi_w;
        logic [15:0] p1;
        sh   = v.s ? 1 : 2;
        gap  = v.s ? 8 : 64;
        lat  = 100 * sh + gap + 1;
        resp = {v.rflag, v.raddr, v.rdata, crc8({v.rflag, v.raddr, v.rdata}) ^ v.crc_flip};
        p1   = {v.wr, v.addr, v.wr ? v.wdata : 8'h00};
        exp1 = {p1, crc8(p1)};
        exp2 = {16'h0000, crc8(16'h0000)};
        frames = 0; rises = 0; fall_cyc = 0; rise_cyc = 0; viol = 0; extra = 0;
        done_seen = 1'b0; poked = 1'b0; mosi_w = '0;

        @(negedge clk);
        sel   = v.s;
        wr    = v.wr;
        addr  = v.addr;
        wdata = v.wdata;
        chk("ready_before", 32'(m_ready), 32'd1);
        req   = 1'b1;
        pcsb  = m_csb;
        psclk = m_sclk;
        pmosi = m_mosi;
        @(negedge clk);
        req = 1'b0;
        chk("ready_drop", 32'(m_ready), 32'd0);
        cyc = 1;
        while (cyc <= 1000 && !done_seen) begin
            if (pcsb && !m_csb) begin
                frames++;
                rises  = 0;
                mosi_w = '0;
                if (frames == 1) chk("csb_fall_cyc", 32'(cyc), 32'd1);
                else             chk("csb_gap", 32'(cyc - rise_cyc), 32'(gap));
                fall_cyc = cyc;
            end
            if (!pcsb && m_csb) begin
                chk("csb_low_len", 32'(cyc - fall_cyc), 32'(50 * sh));
                chk("sclk_rises", 32'(rises), 32'd24);
                if (frames == 1) chk("mosi_frame1", 32'(mosi_w), 32'(exp1));
                else             chk("mosi_frame2", 32'(mosi_w), 32'(exp2));
                rise_cyc = cyc;
            end
            if (!m_csb && !psclk && m_sclk) begin
                mosi_w = {mosi_w[22:0], m_mosi};
                rises++;
            end
            if (psclk && m_sclk && (m_mosi != pmosi)) viol++;
            if (v.poke && frames == 1 && rises == 5 && !poked) begin
                req   = 1'b1;
                poked = 1'b1;
            end else begin
                req = 1'b0;
            end
            if (cyc == 50) chk("rdata_hold", 32'(m_rdata), 32'(last_rd[v.s]));
            if (m_done) begin
                chk("latency", 32'(cyc), 32'(lat));
                chk("rdata", 32'(m_rdata), 32'(v.exp_rdata));
                chk("crc_err", 32'(m_crc), 32'(v.exp_crc));
                chk("rsp_err", 32'(m_rsp), 32'(v.exp_rsp));
                last_rd[v.s] = v.exp_rdata;
                done_seen = 1'b1;
            end
            idx  = 23 - rises;
            miso = (frames == 2 && rises < 24) ? resp[idx] : 1'b1;
            pcsb  = m_csb;
            psclk = m_sclk;
            pmosi = m_mosi;
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        req = 1'b0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("frame_count", 32'(frames), 32'd2);
        chk("mosi_stable_high", 32'(viol), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(m_done), 32'd0);
        chk("ready_back", 32'(m_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (!m_csb) extra++;
            @(negedge clk);
        end
        chk("no_extra_frame", 32'(extra), 32'd0);
        chk("status_hold", 32'(m_rdata), 32'(v.exp_rdata));
    endtask

    initial begin
        int   rises;
        logic psclk;
        //          s  wr  addr   wdata  flg raddr  rdata  flip   poke exp   crc  rsp
        tbl[0] = '{1'b0, 1'b1, 7'h05, 8'h12, 1'b1, 7'h05, 8'h12, 8'h00, 1'b0, 8'h12, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 7'h23, 8'h77, 1'b0, 7'h23, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 7'h23, 8'h00, 1'b0, 7'h23, 8'hA5, 8'h01, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 7'h23, 8'h00, 1'b0, 7'h24, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 7'h7F, 8'hFF, 1'b0, 7'h7F, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 7'h24, 8'h00, 1'b0, 7'h23, 8'hA5, 8'h80, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 7'h05, 8'h12, 1'b1, 7'h05, 8'h12, 8'h00, 1'b0, 8'h12, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 7'h23, 8'h00, 1'b0, 7'h23, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h3C, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0};
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(m_ready), 32'd1);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_rdata", 32'(m_rdata), 32'd0);
        chk("rst_crc_err", 32'(m_crc), 32'd0);
        chk("rst_rsp_err", 32'(m_rsp), 32'd0);
        chk("rst_sclk", 32'(m_sclk), 32'd0);
        chk("rst_csb", 32'(m_csb), 32'd1);
        chk("rst_mosi", 32'(m_mosi), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Async reset at bit 10 of frame 1, then a normal access.
        @(negedge clk);
        sel   = 1'b0;
        wr    = 1'b0;
        addr  = 7'h23;
        req   = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        rises = 0;
        psclk = 1'b0;
        for (int k = 0; k < 500 && rises < 10; k++) begin
            if (!psclk && m_sclk) rises++;
            psclk = m_sclk;
            if (rises < 10) @(negedge clk);
        end
        chk("pre_reset_rises", 32'(rises), 32'd10);
        chk("pre_reset_csb", 32'(m_csb), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_csb", 32'(m_csb), 32'd1);
        chk("mid_rst_sclk", 32'(m_sclk), 32'd0);
        chk("mid_rst_ready", 32'(m_ready), 32'd1);
        chk("mid_rst_mosi", 32'(m_mosi), 32'd0);
        chk("mid_rst_rdata", 32'(m_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        run_txn(tbl[8]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_mst.md
# spi_mst

SPI master that issues register accesses to a remote `spi_slv` over the four-wire link (SCLK/CSB/MOSI/MISO). It serves as the initiator end of the 24-bit CRC-protected register-access protocol.

- Each local request produces two frames:
  - a command frame;
  - a poll frame that collects the slave's response to the command.
- The block checks the response (CRC, type, address) and returns read data and error status to the local requester.
- It runs entirely in the master's SPI kernel clock domain.

## Interface

Parameters:
- REG_AW, 7, register address width (command byte = {wr, addr[6:0]})
- REG_DW, 8, register data width
- REG_CRC_W, 8, CRC width
- SCK_HALF, 2, SCLK half-period in i_spi_sclk cycles (≥1)
- CSB_GAP, 64, CSB-high cycles between frames; must exceed slave CSB sync + register access + 3-cycle ack pipeline
- POLL_ADDR, 7'h00, address used in the poll frame (read)

Ports:
- i_spi_sclk, in, 1, master kernel clock
- i_rst_n, in, 1, reset; asynchronous, active-low. Clock is i_spi_sclk.
- i_req, in, 1, access request; accepted when i_req & o_ready
- i_wr, in, 1, 1 = write, 0 = read
- i_addr, in, REG_AW, register address
- i_wdata, in, REG_DW, write data (ignored for reads)
- o_ready, out, 1, idle, can accept a request
- o_done, out, 1, one-cycle completion pulse
- o_rdata, out, REG_DW, response data (read data, or echoed write data)
- o_crc_err, out, 1, response CRC mismatch; valid with o_done
- o_rsp_err, out, 1, response type or address mismatch; valid with o_done
- o_spi_sclk, out, 1, SPI clock (CPOL=0)
- o_spi_csb, out, 1, chip select, low active
- o_spi_mosi, out, 1, master out
- i_spi_miso, in, 1, slave out

## Operation

- **Accept:** on i_req & o_ready, latch i_wr, i_addr, i_wdata.
  - TX word 1 = {i_wr, i_addr, D, crc(i_wr, i_addr, D)}, where D = i_wdata for writes and 8'h00 for reads.
  - TX word 2 = {1'b0, POLL_ADDR, 8'h00, crc}.
  - crc is computed by `crc16to8_parallel` over {cmd, data}. A second instance checks the RX CRC.
- **Frame format:** 24 bits, MSB first.
  - MOSI changes only while SCLK is low.
  - MISO is sampled on each SCLK rise (registered at the i_spi_sclk edge that drives SCLK high).
- **RX word:** {flag, addr[6:0], data[7:0], crc[7:0]}.
  - Frame 1 RX is discarded.
  - Frame 2 RX is checked.
- **FSM:** IDLE → LEAD → SHIFT → TRAIL → GAP → LEAD (frame 2) → SHIFT → TRAIL → DONE → IDLE. A frame index bit selects TX word and RX handling.
  - IDLE: csb=1, sclk=0, mosi=0, o_ready=1.
  - LEAD: csb=0, sclk=0, mosi=TX[23], for SCK_HALF cycles.
  - SHIFT: half-period counter 0..SCK_HALF-1, toggling sclk at wrap.
    - On a rise: shift MISO into RX.
    - On a fall: bit counter +1; mosi takes the next bit.
    - After the 24th fall, mosi holds 0 → TRAIL.
  - TRAIL: sclk=0, csb=0, for SCK_HALF cycles, then csb=1.
  - GAP: csb=1 for CSB_GAP cycles.
  - DONE: single cycle; o_done=1; outputs updated.
- **Response check:**
  - o_crc_err = crc(RX[23:8]) ≠ RX[7:0].
  - o_rsp_err = !o_crc_err & (RX[23] ≠ wr | RX[22:16] ≠ addr).
  - o_rdata = RX[15:8].
- **Request while busy:** ignored, not queued.
- **Flow:** no back-to-back path; after DONE the FSM spends at least one cycle in IDLE.

## Timing

- **Reset values:** o_ready=1, o_done=0, o_rdata=0, o_crc_err=0, o_rsp_err=0, o_spi_sclk=0, o_spi_csb=1, o_spi_mosi=0.
- **Async reset mid-frame:** outputs return to reset values immediately; FSM returns to IDLE. The remote slave sees a truncated frame, which it flags as a CRC error.
- All outputs are registered; no combinational path from i_spi_miso to outputs.
- **Cycle budget:**
  - Accept at cycle 0 → csb falls at cycle 1.
  - CSB-low length per frame = (2 + 48)·SCK_HALF cycles (100 at default).
- **Request latency:** from accept to o_done = 2·(50·SCK_HALF) + CSB_GAP + 1 cycles (265 at default).
- **Hold rules:**
  - o_rdata and error flags hold until the next o_done.
  - o_ready deasserts in the cycle after accept and reasserts the cycle after o_done.

## Test plan

- **Write:** write addr 0x05 data 0x12; slave model acks → MOSI frame 1 = 0x85, 0x12, crc(0x8512). Response {1, 0x05, 0x12, crc} → o_done with o_rdata=0x12, both errors 0.
- **Read:** read addr 0x23; slave returns {0, 0x23, 0xA5, crc} → MOSI 0x23, 0x00, crc. o_done with o_rdata=0xA5, no error; frame 2 cmd = POLL_ADDR read.
- **Corrupt CRC:** flip one response CRC bit → o_crc_err=1, o_rsp_err=0. Address mismatch (0x24 returned for 0x23) → o_rsp_err=1.
- **Framing and busy:**
  - Each CSB-low window holds exactly 24 SCLK rises.
  - CSB-high gap = CSB_GAP cycles.
  - i_req pulsed during SHIFT is ignored (no extra frames).
- **Reset mid-operation:** assert i_rst_n low at bit 10 of frame 1 → csb=1, sclk=0, o_ready=1 immediately. The next request completes normally.
- **Parameters:** SCK_HALF=1 and CSB_GAP=8 → SCLK = clk/2; latency = 2·50 + 8 + 1 = 109 cycles.
